// File: rtl/ps2_scan_sequencer_pkg.sv
// Shared constants and types for the PS/2 scancode sequencer.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_BAT  = 8'hAA;
  localparam logic [7:0] PS2_ACK  = 8'hFA;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EMIT
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       ext;
    logic [7:0] code;
  } held_entry_t;

endpackage

// File: rtl/ps2_scan_sequencer_held_table.sv
// Table of currently held keys: combinational lookup on {ext, code}, registered insert/invalidate.
module ps2_held_table
  import ps2_pkg::*;
#(
  parameter int HELD_DEPTH = 4
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_ext,
  input  logic [7:0] key_code,
  input  logic       insert,
  input  logic       remove,
  output logic       hit,
  output logic       full,
  output logic [3:0] count
);

  held_entry_t           tbl [HELD_DEPTH];
  logic [HELD_DEPTH-1:0] match_vec;
  logic [HELD_DEPTH-1:0] ins_sel;
  logic                  taken;

  always_comb begin
    match_vec = '0;
    ins_sel   = '0;
    taken     = 1'b0;
    count     = 4'd0;
    for (int i = 0; i < HELD_DEPTH; i++) begin
      match_vec[i] = tbl[i].valid && (tbl[i].ext == key_ext) && (tbl[i].code == key_code);
      // Lowest-index free slot receives a new key.
      if (!tbl[i].valid && !taken) begin
        ins_sel[i] = 1'b1;
        taken      = 1'b1;
      end
      count = count + 4'(tbl[i].valid);
    end
    hit  = |match_vec;
    full = !taken;
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      for (int i = 0; i < HELD_DEPTH; i++) tbl[i] <= '0;
    end else begin
      for (int i = 0; i < HELD_DEPTH; i++) begin
        if (insert && ins_sel[i]) begin
          tbl[i].valid <= 1'b1;
          tbl[i].ext   <= key_ext;
          tbl[i].code  <= key_code;
        end else if (remove && match_vec[i]) begin
          tbl[i].valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// PS/2 receive-FIFO sequencer: pops bytes, strips E0/F0 prefixes, tracks held keys, emits events.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses make events for keys already held.
module ps2_scan_sequencer
  import ps2_pkg::*;
#(
  parameter int HELD_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic [3:0]       held_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  state_t     state;
  logic [7:0] byte_r;
  logic       ext_f;
  logic       brk_f;
  logic       ovf_d;

  logic is_ext, is_brk, is_err, is_drop, is_key;
  logic in_dec, hit, full, suppress, tbl_insert, tbl_remove, ovf_rise, err_inc;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

  assign is_ext  = (byte_r == PS2_EXT);
  assign is_brk  = (byte_r == PS2_BRK);
  assign is_err  = (byte_r == PS2_ERR0) || (byte_r == PS2_ERR1);
  assign is_drop = (byte_r == PS2_BAT) || (byte_r == PS2_ACK);
  assign is_key  = !(is_ext || is_brk || is_err || is_drop);
  assign in_dec  = (state == S_DECODE);

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign suppress = is_key && !brk_f && hit;
`else
  assign suppress = 1'b0;
`endif

  assign tbl_insert = in_dec && is_key && !brk_f && !hit && !full && !clrn;
  assign tbl_remove = in_dec && is_key && brk_f && hit && !clrn;
  assign ovf_rise   = overflow && !ovf_d;
  // An error byte and an overflow edge in the same cycle count once.
  assign err_inc    = ovf_rise || (in_dec && is_err);
  assign nextdata_n = !((state == S_IDLE) && ready && !clrn);

  ps2_held_table #(.HELD_DEPTH(HELD_DEPTH)) u_held (
    .clk      (clk),
    .clrn     (clrn),
    .key_ext  (ext_f),
    .key_code (byte_r),
    .insert   (tbl_insert),
    .remove   (tbl_remove),
    .hit      (hit),
    .full     (full),
    .count    (held_cnt)
  );

  always_ff @(posedge clk) begin
    if (clrn) begin
      state    <= S_IDLE;
      byte_r   <= 8'h00;
      ext_f    <= 1'b0;
      brk_f    <= 1'b0;
      ovf_d    <= 1'b0;
      ev_valid <= 1'b0;
      ev_code  <= 8'h00;
      ev_ext   <= 1'b0;
      ev_break <= 1'b0;
      err_cnt  <= '0;
    end else begin
      ovf_d <= overflow;
      if (err_inc) err_cnt <= sat_inc(err_cnt);
      case (state)
        S_IDLE: begin
          if (ready) begin
            byte_r <= data;
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          state <= S_IDLE;
          if (is_ext) begin
            ext_f <= 1'b1;
          end else if (is_brk) begin
            brk_f <= 1'b1;
          end else if (is_err || is_drop || suppress) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
          end else begin
            ev_code  <= byte_r;
            ev_ext   <= ext_f;
            ev_break <= brk_f;
            ev_valid <= 1'b1;
            ext_f    <= 1'b0;
            brk_f    <= 1'b0;
            state    <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (ev_ready) begin
            ev_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Overflow discards any partially received prefix, overriding a prefix set above.
      if (ovf_rise) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer with a queue model of the receive FIFO.
module tb_ps2_scan_sequencer;

  logic       clk = 1'b0;
  logic       clrn, ready, overflow, nextdata_n, ev_valid, ev_ready, ev_ext, ev_break;
  logic [7:0] data, ev_code, err_cnt;
  logic [3:0] held_cnt;

  logic [7:0] fifo [$];
  logic [9:0] evlog [$];
  int         pops, held_max, checks, errors;
  logic       stable;

  always #5 clk = ~clk;

  ps2_scan_sequencer #(.HELD_DEPTH(4), .ERR_W(8)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ready      (ready),
    .data       (data),
    .overflow   (overflow),
    .nextdata_n (nextdata_n),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_break   (ev_break),
    .held_cnt   (held_cnt),
    .err_cnt    (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    ready = (fifo.size() > 0);
    data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    drive_fifo();
  endtask

  // One clock: sample handshakes before the edge, update the FIFO model after it.
  task automatic step();
    logic pop;
    #1;
    pop = !nextdata_n;
    if (ev_valid && ev_ready) evlog.push_back({ev_ext, ev_break, ev_code});
    @(posedge clk);
    #1;
    if (pop) begin
      pops++;
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    drive_fifo();
    @(negedge clk);
    if (int'(held_cnt) > held_max) held_max = int'(held_cnt);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    checks = 0; errors = 0; pops = 0; held_max = 0;
    clrn = 1'b1; overflow = 1'b0; ev_ready = 1'b1;
    drive_fifo();
    @(negedge clk);
    run(2);
    clrn = 1'b0;
    check("rst_nextdata_n", nextdata_n, 1);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_code", ev_code, 0);
    check("rst_held_cnt", held_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);

    // press and release 1C
    pops = 0; held_max = 0; evlog.delete();
    push(8'h1C); push(8'hF0); push(8'h1C);
    run(14);
    check("t1_events", evlog.size(), 2);
    check("t1_ev0", evlog[0], 10'h01C);
    check("t1_ev1", evlog[1], 10'h11C);
    check("t1_pops", pops, 3);
    check("t1_held_peak", held_max, 1);
    check("t1_held_end", held_cnt, 0);

    // extended and plain 75 are distinct keys
    held_max = 0; evlog.delete();
    push(8'hE0); push(8'h75); push(8'h75);
    push(8'hE0); push(8'hF0); push(8'h75);
    push(8'hF0); push(8'h75);
    run(30);
    check("t2_events", evlog.size(), 4);
    check("t2_ev0", evlog[0], 10'h275);
    check("t2_ev1", evlog[1], 10'h075);
    check("t2_ev2", evlog[2], 10'h375);
    check("t2_ev3", evlog[3], 10'h175);
    check("t2_held_peak", held_max, 2);
    check("t2_held_end", held_cnt, 0);

    // typematic repeats
    held_max = 0; evlog.delete();
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    run(22);
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("t3_events", evlog.size(), 2);
    check("t3_break", evlog[1], 10'h11C);
`else
    check("t3_events", evlog.size(), 4);
    check("t3_repeat", evlog[2], 10'h01C);
`endif
    check("t3_held_peak", held_max, 1);
    check("t3_held_end", held_cnt, 0);

    // backpressure
    ev_ready = 1'b0; evlog.delete();
    push(8'h15); push(8'h16); push(8'h17);
    run(6);
    check("t4_valid", ev_valid, 1);
    check("t4_code", ev_code, 8'h15);
    pops = 0; stable = 1'b1;
    repeat (10) begin
      step();
      if (!(ev_valid === 1'b1 && ev_code === 8'h15 && ev_break === 1'b0)) stable = 1'b0;
    end
    check("t4_stable", stable, 1);
    check("t4_no_pop", pops, 0);
    ev_ready = 1'b1;
    run(2);
    check("t4_pop_after_release", pops > 0, 1);
    check("t4_ev0", evlog[0], 10'h015);
    push(8'hF0); push(8'h15); push(8'hF0); push(8'h16); push(8'hF0); push(8'h17);
    run(40);
    check("t4_events", evlog.size(), 6);
    check("t4_held_end", held_cnt, 0);

    // table full
    evlog.delete();
    push(8'h1C); push(8'h32); push(8'h21); push(8'h23); push(8'h2B);
    run(25);
    check("t5_makes", evlog.size(), 5);
    check("t5_held_full", held_cnt, 4);
    push(8'hF0); push(8'h2B);
    run(8);
    check("t5_events", evlog.size(), 6);
    check("t5_stray_break", evlog[5], 10'h12B);
    check("t5_held_still", held_cnt, 4);
    push(8'hF0); push(8'h1C); push(8'hF0); push(8'h32);
    push(8'hF0); push(8'h21); push(8'hF0); push(8'h23);
    run(30);
    check("t5_held_end", held_cnt, 0);

    // overflow cancels prefix, error bytes count
    push(8'hE0);
    run(4);
    overflow = 1'b1; step();
    overflow = 1'b0; step();
    check("t6_err_ovf", err_cnt, 1);
    evlog.delete();
    push(8'h75);
    run(6);
    check("t6_events", evlog.size(), 1);
    check("t6_ev0", evlog[0], 10'h075);
    push(8'hFF);
    run(4);
    check("t6_err_byte", err_cnt, 2);
    check("t6_no_event", evlog.size(), 1);
    check("t6_held", held_cnt, 1);
    repeat (260) begin
      overflow = 1'b1; step();
      overflow = 1'b0; step();
    end
    check("t6_err_sat", err_cnt, 8'hFF);

    // reset while an event is pending
    ev_ready = 1'b0;
    push(8'h33);
    run(4);
    check("t7_pending", ev_valid, 1);
    clrn = 1'b1;
    fifo.delete();
    drive_fifo();
    step();
    clrn = 1'b0;
    check("t7_ev_valid", ev_valid, 0);
    check("t7_ev_code", ev_code, 0);
    check("t7_held", held_cnt, 0);
    check("t7_err", err_cnt, 0);
    check("t7_nextdata_n", nextdata_n, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
